mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL: aluop_i  in  AluOpBus  opcode from the execute stage.
REQ-004 SHALL: wd_i  in  5  destination register; wreg_i  in  1  write enable; wdata_i  in  32  execute result.
REQ-005 SHALL: mem_addr_i  in  32  byte address; reg2_i  in  32  store data.
REQ-006 SHALL: bus_req_o  out  1; bus_we_o  out  1; bus_addr_o  out  32 (word-aligned); bus_be_o  out  4; bus_wdata_o  out  32.
REQ-007 SHALL: bus_ack_i  in  1  completes the request in the same cycle; bus_rdata_i  in  32  valid when bus_ack_i=1.
REQ-008 SHALL: wd_o  out  5; wreg_o  out  1; wdata_o  out  32; all registered, to writeback.
REQ-009 SHALL: stallreq  out  1  holds upstream stages while an access is pending.
REQ-010 SHALL: addr_err_o  out  1  one-cycle pulse on a misaligned access; bus_err_o  out  1  one-cycle pulse on a timeout.

Function
REQ-011 SHALL: memory ops are ALU_OP_LW, LB, LH, SW, SB, SH; every other opcode is a non-memory op.
REQ-012 SHALL: a non-memory op reaches wd_o/wreg_o/wdata_o one cycle later, with stallreq=0 and no bus activity.
REQ-013 SHALL: FSM has two states, IDLE and BUSY.
REQ-014 SHALL: in IDLE, an aligned memory op drives stallreq=1 combinationally, latches op, address, data and wd, and moves to BUSY.
REQ-015 SHALL: in BUSY, bus_req_o=1 and the bus outputs stay stable until the ack.
REQ-016 SHALL: in BUSY, stallreq = ~bus_ack_i; this combinational ack-to-stall path is intended.
REQ-017 SHALL: BUSY with bus_ack_i=1 loads the writeback registers, moves to IDLE, and drops bus_req_o on the next cycle.
REQ-018 SHALL: the held instruction is issued exactly once.
REQ-019 SHALL: alignment rules:
- LW/SW need addr[1:0]=0.
- LH/SH need addr[0]=0.
- On violation: no bus request, stallreq=0, wreg_o=0 next cycle, addr_err_o pulses.
REQ-020 SHALL: byte lanes are little-endian; addr[1:0]=0 selects bits 7:0.
REQ-021 SHALL: byte enables:
- SW: 1111.
- SH: 0011 or 1100 per addr[1].
- SB: one-hot 1<<addr[1:0].
- Loads: 1111.
REQ-022 SHALL: store data: SB replicates reg2_i[7:0] ×4; SH replicates reg2_i[15:0] ×2.
REQ-023 SHALL: LB and LH sign-extend the selected byte/half to 32 bits; LW passes bus_rdata_i through.
REQ-024 SHALL: stores finish with wreg_o=0; loads finish with wreg_o as latched.
REQ-025 SHALL: an 8-bit counter clears on BUSY entry and increments each BUSY cycle without ack.
REQ-026 SHALL: on count 255 without ack: abort to IDLE, bus_req_o=0, stallreq=0, wreg_o=0, bus_err_o pulses.
REQ-027 SHALL: an ack in the same cycle as count 255 counts as success.
REQ-028 SHALL: bus_ack_i seen in IDLE is ignored.

Reset
REQ-029 SHALL: rst=0 at a clock edge forces:
- state IDLE, counter 0;
- bus_req_o=0, bus_we_o=0, bus_be_o=0, bus_addr_o=0, bus_wdata_o=0;
- wd_o=0, wreg_o=WriteDisable, wdata_o=ZeroWord;
- stallreq=0, addr_err_o=0, bus_err_o=0.
REQ-030 SHALL: reset during BUSY abandons the access with no writeback; an ack arriving after reset is ignored.

Structure
REQ-031 SHALL: opcode codes, AluOpBus, RegBus, RegAddrBus, WriteBus, ZeroWord and the timeout limit (255) live in the shared defines file.
REQ-032 SHALL: a combinational sub-module load_align holds load lane extraction and sign extension.

Verification
REQ-033 SHALL: ALU_OP_ADDU, wdata_i=0x5, wd_i=3 -> next cycle wd_o=3, wreg_o=1, wdata_o=0x5; bus_req_o stays 0.
REQ-034 SHALL: LB at addr 0x1003, ack after 3 cycles with rdata 0x80FF_FF00 -> wdata_o=0xFFFF_FF80; stallreq high 4 cycles total.
REQ-035 SHALL: SH at addr 0x2002, reg2_i=0x0000_BEEF -> bus_be_o=1100, bus_wdata_o=0xBEEF_BEEF, bus_we_o=1, wreg_o=0.
REQ-036 SHALL: LW at addr 0x3001 -> addr_err_o pulse, bus_req_o never high, wreg_o=0.
REQ-037 SHALL: LW with no ack -> bus_err_o after 255 BUSY cycles, stallreq drops, IDLE reached.
REQ-038 SHALL: rst=0 on the 2nd BUSY cycle, ack 1 cycle later -> no writeback, all outputs at reset values.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-access stage: bus widths, opcode codes,
// the bus timeout limit and small opcode-decoding helpers.
package mem_ctrl_pkg;

  typedef logic [7:0]  AluOpBus;
  typedef logic [31:0] RegBus;
  typedef logic [4:0]  RegAddrBus;
  typedef logic        WriteBus;

  localparam WriteBus    WriteEnable  = 1'b1;
  localparam WriteBus    WriteDisable = 1'b0;
  localparam RegBus      ZeroWord     = 32'h0000_0000;
  localparam logic [7:0] TimeoutLimit = 8'd255;

  localparam AluOpBus ALU_OP_NOP  = 8'h00;
  localparam AluOpBus ALU_OP_ADDU = 8'h01;
  localparam AluOpBus ALU_OP_SUBU = 8'h02;
  localparam AluOpBus ALU_OP_AND  = 8'h03;
  localparam AluOpBus ALU_OP_OR   = 8'h04;
  localparam AluOpBus ALU_OP_LB   = 8'h10;
  localparam AluOpBus ALU_OP_LH   = 8'h11;
  localparam AluOpBus ALU_OP_LW   = 8'h12;
  localparam AluOpBus ALU_OP_SB   = 8'h18;
  localparam AluOpBus ALU_OP_SH   = 8'h19;
  localparam AluOpBus ALU_OP_SW   = 8'h1a;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  function automatic logic is_mem_op(input AluOpBus op);
    return op inside {ALU_OP_LB, ALU_OP_LH, ALU_OP_LW, ALU_OP_SB, ALU_OP_SH, ALU_OP_SW};
  endfunction

  function automatic logic is_store_op(input AluOpBus op);
    return op inside {ALU_OP_SB, ALU_OP_SH, ALU_OP_SW};
  endfunction

  function automatic mem_size_e op_size(input AluOpBus op);
    mem_size_e sz;
    if (op == ALU_OP_LB || op == ALU_OP_SB)      sz = SZ_BYTE;
    else if (op == ALU_OP_LH || op == ALU_OP_SH) sz = SZ_HALF;
    else                                         sz = SZ_WORD;
    return sz;
  endfunction

  function automatic logic is_aligned(input mem_size_e sz, input logic [1:0] off);
    logic ok;
    unique case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a little-endian bus word and
// sign-extends it; full-word loads pass straight through.
module load_align
  import mem_ctrl_pkg::*;
(
  input  mem_size_e  size_i,
  input  logic [1:0] offset_i,
  input  RegBus      rdata_i,
  output RegBus      data_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rdata_i[7:0];
    unique case (offset_i)
      2'd0: lane_byte = rdata_i[7:0];
      2'd1: lane_byte = rdata_i[15:8];
      2'd2: lane_byte = rdata_i[23:16];
      2'd3: lane_byte = rdata_i[31:24];
      default: lane_byte = rdata_i[7:0];
    endcase
    lane_half = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    unique case (size_i)
      SZ_BYTE: data_o = {{24{lane_byte[7]}}, lane_byte};
      SZ_HALF: data_o = {{16{lane_half[15]}}, lane_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory-access pipeline stage: passes ALU results to writeback and runs
// single-request bus transactions for loads/stores with alignment and timeout checks.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  AluOpBus    aluop_i,
  input  RegAddrBus  wd_i,
  input  WriteBus    wreg_i,
  input  RegBus      wdata_i,
  input  RegBus      mem_addr_i,
  input  RegBus      reg2_i,
  output logic       bus_req_o,
  output logic       bus_we_o,
  output RegBus      bus_addr_o,
  output logic [3:0] bus_be_o,
  output RegBus      bus_wdata_o,
  input  logic       bus_ack_i,
  input  RegBus      bus_rdata_i,
  output RegAddrBus  wd_o,
  output WriteBus    wreg_o,
  output RegBus      wdata_o,
  output logic       stallreq,
  output logic       addr_err_o,
  output logic       bus_err_o,
  output state_e     state_dbg_o
);

  // Bus handshake: bus_req_o stays high with stable we/addr/be/wdata from the
  // first BUSY cycle until a cycle in which bus_ack_i=1; that cycle completes
  // the access and bus_rdata_i is valid only then.

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  mem_size_e  size_q, size_d;
  logic [1:0] off_q, off_d;
  logic       store_q, store_d;
  RegAddrBus  wd_q, wd_d;
  WriteBus    wreg_q, wreg_d;
  RegBus      addr_q, addr_d;
  logic [3:0] be_q, be_d;
  RegBus      bwdata_q, bwdata_d;
  RegAddrBus  wb_wd_q, wb_wd_d;
  WriteBus    wb_wreg_q, wb_wreg_d;
  RegBus      wb_data_q, wb_data_d;
  logic       addr_err_q, addr_err_d;
  logic       bus_err_q, bus_err_d;

  mem_size_e  req_size;
  logic [3:0] req_be;
  RegBus      req_wdata;
  RegBus      load_data;

  load_align u_load_align (
    .size_i   (size_q),
    .offset_i (off_q),
    .rdata_i  (bus_rdata_i),
    .data_o   (load_data)
  );

  always_comb begin
    req_size  = op_size(aluop_i);
    req_be    = 4'hF;
    req_wdata = reg2_i;
    unique case (req_size)
      SZ_BYTE: begin
        req_be    = 4'b0001 << mem_addr_i[1:0];
        req_wdata = {4{reg2_i[7:0]}};
      end
      SZ_HALF: begin
        req_be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{reg2_i[15:0]}};
      end
      default: begin
        req_be    = 4'hF;
        req_wdata = reg2_i;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    off_d      = off_q;
    store_d    = store_q;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    addr_d     = addr_q;
    be_d       = be_q;
    bwdata_d   = bwdata_q;
    wb_wd_d    = '0;
    wb_wreg_d  = WriteDisable;
    wb_data_d  = ZeroWord;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    stallreq   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!is_mem_op(aluop_i)) begin
          wb_wd_d   = wd_i;
          wb_wreg_d = wreg_i;
          wb_data_d = wdata_i;
        end else if (!is_aligned(req_size, mem_addr_i[1:0])) begin
          wb_wd_d    = wd_i;
          addr_err_d = 1'b1;
        end else begin
          stallreq = 1'b1;
          state_d  = ST_BUSY;
          cnt_d    = 8'd0;
          size_d   = req_size;
          off_d    = mem_addr_i[1:0];
          store_d  = is_store_op(aluop_i);
          wd_d     = wd_i;
          wreg_d   = wreg_i;
          addr_d   = {mem_addr_i[31:2], 2'b00};
          be_d     = req_be;
          bwdata_d = is_store_op(aluop_i) ? req_wdata : ZeroWord;
        end
      end
      ST_BUSY: begin
        // An ack wins over the timeout even on the final counted cycle.
        if (bus_ack_i) begin
          state_d   = ST_IDLE;
          wb_wd_d   = wd_q;
          wb_wreg_d = store_q ? WriteDisable : wreg_q;
          wb_data_d = store_q ? ZeroWord : load_data;
        end else if (cnt_q == TimeoutLimit) begin
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
        end else begin
          stallreq = 1'b1;
          cnt_d    = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      size_q     <= SZ_BYTE;
      off_q      <= 2'b00;
      store_q    <= 1'b0;
      wd_q       <= '0;
      wreg_q     <= WriteDisable;
      addr_q     <= ZeroWord;
      be_q       <= 4'h0;
      bwdata_q   <= ZeroWord;
      wb_wd_q    <= '0;
      wb_wreg_q  <= WriteDisable;
      wb_data_q  <= ZeroWord;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      off_q      <= off_d;
      store_q    <= store_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      bwdata_q   <= bwdata_d;
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_data_q  <= wb_data_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign bus_req_o   = (state_q == ST_BUSY);
  assign bus_we_o    = store_q;
  assign bus_addr_o  = addr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = bwdata_q;
  assign wd_o        = wb_wd_q;
  assign wreg_o      = wb_wreg_q;
  assign wdata_o     = wb_data_q;
  assign addr_err_o  = addr_err_q;
  assign bus_err_o   = bus_err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized scoreboard bench for mem_ctrl: a driver issues instructions and
// predicts results, a bus responder acks, and a monitor checks writeback/error events.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  AluOpBus    aluop_i;
  RegAddrBus  wd_i;
  WriteBus    wreg_i;
  RegBus      wdata_i, mem_addr_i, reg2_i;
  logic       bus_req_o, bus_we_o;
  RegBus      bus_addr_o, bus_wdata_o;
  logic [3:0] bus_be_o;
  logic       bus_ack_i;
  RegBus      bus_rdata_i;
  RegAddrBus  wd_o;
  WriteBus    wreg_o;
  RegBus      wdata_o;
  logic       stallreq, addr_err_o, bus_err_o;
  state_e     state_dbg;

  int checks = 0;
  int errors = 0;

  // Writeback/error events {bus_err, addr_err, wd, wdata} in program order.
  logic [38:0] exp_q[$];
  // Expected bus request {we, addr, be, wdata} plus its responder plan.
  logic [68:0] bus_exp_q[$];
  int          delay_q[$];
  logic [31:0] rdata_q[$];

  logic  resp_en  = 1'b0;
  logic  dir_ack  = 1'b0;
  RegBus dir_rdata = '0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .mem_addr_i  (mem_addr_i),
    .reg2_i      (reg2_i),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_be_o    (bus_be_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stallreq    (stallreq),
    .addr_err_o  (addr_err_o),
    .bus_err_o   (bus_err_o),
    .state_dbg_o (state_dbg)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor: every writeback or error pulse must match the head of exp_q.
  always @(negedge clk) begin
    logic [38:0] act;
    if (rst && (wreg_o || addr_err_o || bus_err_o)) begin
      act = {bus_err_o, addr_err_o, (wreg_o ? wd_o : 5'd0), (wreg_o ? wdata_o : 32'd0)};
      if (exp_q.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        check("wb_event", 128'(act), 128'(exp_q.pop_front()));
      end
    end
  end

  // Bus responder: takes the next plan on a new request, checks the request
  // stays stable, acks after the planned delay, idles with random stray acks.
  logic        r_active = 1'b0;
  int          r_delay, r_wait, r_cycles;
  logic [68:0] r_exp;
  logic [31:0] r_rdata;

  always @(posedge clk) begin
    #1;
    if (!resp_en) begin
      bus_ack_i   = dir_ack;
      bus_rdata_i = dir_rdata;
    end else if (bus_req_o) begin
      if (!r_active) begin
        r_active = 1'b1;
        r_wait   = 0;
        r_cycles = 0;
        if (bus_exp_q.size() == 0) begin
          fail_now("unexpected_bus_req");
          r_exp = '0; r_delay = 0; r_rdata = '0;
        end else begin
          r_exp   = bus_exp_q.pop_front();
          r_delay = delay_q.pop_front();
          r_rdata = rdata_q.pop_front();
        end
      end
      r_cycles++;
      check("bus_request", 128'({bus_we_o, bus_addr_o, bus_be_o, (bus_we_o ? bus_wdata_o : 32'd0)}),
            128'(r_exp));
      if (r_wait == r_delay) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = r_rdata;
      end else begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = $urandom;
        r_wait++;
      end
    end else begin
      if (r_active) begin
        check("req_length", 128'(r_cycles), 128'((r_delay > 255) ? 256 : r_delay + 1));
        r_active = 1'b0;
      end
      bus_ack_i   = ($urandom_range(0, 3) == 0);
      bus_rdata_i = $urandom;
    end
  end

  // Driver plus reference model: predict every effect of one instruction,
  // present it, and hold it until the stage stops stalling.
  task automatic issue(input AluOpBus op, input RegAddrBus wd, input WriteBus wreg,
                       input RegBus wdata, input RegBus addr, input RegBus reg2,
                       input int delay, input RegBus rdata);
    logic        is_load, is_store;
    int          size, exp_stall, stalls;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] bdata, lane, val;
    is_load  = (op == ALU_OP_LB || op == ALU_OP_LH || op == ALU_OP_LW);
    is_store = (op == ALU_OP_SB || op == ALU_OP_SH || op == ALU_OP_SW);
    size     = (op == ALU_OP_LB || op == ALU_OP_SB) ? 1 :
               (op == ALU_OP_LH || op == ALU_OP_SH) ? 2 : 4;
    off      = addr[1:0];
    exp_stall = 0;
    if (!(is_load || is_store)) begin
      if (wreg) exp_q.push_back({2'b00, wd, wdata});
    end else if ((addr % size) != 0) begin
      exp_q.push_back({2'b01, 37'd0});
    end else begin
      exp_stall = 1 + ((delay > 255) ? 255 : delay);
      if (size == 1) begin
        be = 4'b0001 << off; bdata = {4{reg2[7:0]}};
      end else if (size == 2) begin
        be = (off == 2'd2) ? 4'b1100 : 4'b0011; bdata = {2{reg2[15:0]}};
      end else begin
        be = 4'b1111; bdata = reg2;
      end
      bus_exp_q.push_back({is_store, addr & 32'hFFFF_FFFC, be, (is_store ? bdata : 32'd0)});
      delay_q.push_back(delay);
      rdata_q.push_back(rdata);
      if (delay > 255) begin
        exp_q.push_back({2'b10, 37'd0});
      end else if (is_load && wreg) begin
        lane = rdata >> (8 * off);
        if (size == 1)      val = {{24{lane[7]}}, lane[7:0]};
        else if (size == 2) val = {{16{lane[15]}}, lane[15:0]};
        else                val = rdata;
        exp_q.push_back({2'b00, wd, val});
      end
    end

    @(posedge clk); #1;
    aluop_i = op; wd_i = wd; wreg_i = wreg; wdata_i = wdata; mem_addr_i = addr; reg2_i = reg2;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stallreq) break;
      stalls++;
      if (stalls > 400) begin
        fail_now("stall_bound");
        break;
      end
    end
    check("stall_cycles", 128'(stalls), 128'(exp_stall));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bus"}, 128'({bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o}), 128'(0));
    check({tag, "_wb"}, 128'({wd_o, wreg_o, wdata_o}), 128'(0));
    check({tag, "_flags"}, 128'({stallreq, addr_err_o, bus_err_o}), 128'(0));
    check({tag, "_state"}, 128'(state_dbg), 128'(ST_IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    AluOpBus op_tab[12];
    op_tab = '{ALU_OP_NOP, ALU_OP_ADDU, ALU_OP_SUBU, ALU_OP_AND, ALU_OP_OR, 8'h7f,
               ALU_OP_LB, ALU_OP_LH, ALU_OP_LW, ALU_OP_SB, ALU_OP_SH, ALU_OP_SW};

    rst = 1'b0;
    aluop_i = ALU_OP_NOP; wd_i = '0; wreg_i = 1'b0; wdata_i = '0; mem_addr_i = '0; reg2_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_init");
    rst = 1'b1;

    // Reset on the second BUSY cycle of a load, ack arriving one cycle later.
    @(posedge clk); #1;
    aluop_i = ALU_OP_LW; mem_addr_i = 32'h40; wd_i = 5'd7; wreg_i = 1'b1;
    @(negedge clk);
    check("rst_test_idle_stall", 128'(stallreq), 128'(1));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_test_busy_req", 128'(bus_req_o), 128'(1));
    rst = 1'b0;
    dir_ack = 1'b1;
    dir_rdata = 32'h1234_5678;
    @(posedge clk); #2;
    rst = 1'b1;
    aluop_i = ALU_OP_NOP; wreg_i = 1'b0;
    @(negedge clk);
    check_reset_values("reset_mid_busy");
    dir_ack = 1'b0;
    @(negedge clk);
    check("late_ack_ignored", 128'({bus_req_o, wreg_o, stallreq}), 128'(0));

    resp_en = 1'b1;
    issue(ALU_OP_ADDU, 5'd3, 1'b1, 32'h5, 32'h0, 32'h0, 0, 32'h0);
    issue(ALU_OP_LB,   5'd4, 1'b1, 32'h0, 32'h1003, 32'h0, 3, 32'h80FF_FF00);
    issue(ALU_OP_SH,   5'd5, 1'b1, 32'h0, 32'h2002, 32'h0000_BEEF, 1, 32'h0);
    issue(ALU_OP_LW,   5'd6, 1'b1, 32'h0, 32'h3001, 32'h0, 0, 32'h0);
    issue(ALU_OP_LW,   5'd8, 1'b1, 32'h0, 32'h4000, 32'h0, 300, 32'h0);
    issue(ALU_OP_LW,   5'd9, 1'b1, 32'h0, 32'h5004, 32'h0, 255, 32'hCAFE_F00D);
    issue(ALU_OP_LH,   5'd10, 1'b1, 32'h0, 32'h6002, 32'h0, 0, 32'h8001_7FFF);
    issue(ALU_OP_SB,   5'd11, 1'b1, 32'h0, 32'h7001, 32'h0000_00A5, 2, 32'h0);

    for (int i = 0; i < 150; i++) begin
      AluOpBus op;
      int      dly;
      op  = op_tab[$urandom_range(0, 11)];
      dly = (i == 75) ? 300 : $urandom_range(0, 6);
      issue(op, 5'($urandom), 1'($urandom), $urandom,
            {$urandom_range(0, 32'hFFFF) , 16'h0} | 32'($urandom_range(0, 15)),
            $urandom, dly, $urandom);
    end

    @(posedge clk); #1;
    aluop_i = ALU_OP_NOP; wreg_i = 1'b0;
    repeat (5) @(negedge clk);
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    check("bus_q_drained", 128'(bus_exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
